// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the SERV RAM arbiter/bridge.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic GNT_IBUS = 1'b0;
    localparam logic GNT_DBUS = 1'b1;

endpackage

// File: rtl/wb_ram_arb_arb2_rr.sv
// Two-way round-robin arbiter: one-hot grant (bit 0 ibus, bit 1 dbus) plus
// the register remembering which master won last.
module arb2_rr
    import wb_ram_pkg::*;
(
    input  logic       ck,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = '0;
        if (req[0] && req[1])
            gnt = (last_grant == GNT_IBUS) ? 2'b10 : 2'b01;
        else
            gnt = req;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            last_grant <= GNT_IBUS;
        else if (take && (|req))
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/wb_ram_arb.sv
// Arbitrates the SERV instruction and data buses onto a single-port word RAM;
// one transaction at a time, IDLE -> ACCESS -> ACK.
module wb_ram_arb
    import wb_ram_pkg::*;
#(
    parameter  int WORDS = 256,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        ibus_cyc,
    input  logic [31:0] ibus_adr,
    output logic [31:0] ibus_rdt,
    output logic        ibus_ack,
    input  logic        dbus_cyc,
    input  logic        dbus_we,
    input  logic [3:0]  dbus_sel,
    input  logic [31:0] dbus_adr,
    input  logic [31:0] dbus_dat,
    output logic [31:0] dbus_rdt,
    output logic        dbus_ack,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t     state;
    logic       grant;
    logic [1:0] gnt;
    logic       unused_adr_bits;

    assign unused_adr_bits = ^{ibus_adr[31:AW+2], ibus_adr[1:0],
                               dbus_adr[31:AW+2], dbus_adr[1:0]};

    arb2_rr u_arb (
        .ck    (ck),
        .rst_n (rst_n),
        .req   ({dbus_cyc, ibus_cyc}),
        .take  (state == IDLE),
        .gnt   (gnt)
    );

    // RAM data only becomes valid after the ACCESS edge, so rdt is steered
    // combinationally by the registered ack rather than registered itself.
    assign ibus_rdt = ibus_ack ? ram_rdata : '0;
    assign dbus_rdt = dbus_ack ? ram_rdata : '0;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= GNT_IBUS;
            ibus_ack  <= 1'b0;
            dbus_ack  <= 1'b0;
            ram_cyc   <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ibus_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                    if (|gnt) begin
                        state   <= ACCESS;
                        grant   <= gnt[1];
                        ram_cyc <= 1'b1;
                        if (gnt[1]) begin
                            ram_addr  <= 32'(dbus_adr[AW+1:2]);
                            ram_we    <= dbus_we;
                            ram_sel   <= dbus_sel;
                            ram_wdata <= dbus_dat;
                        end else begin
                            ram_addr  <= 32'(ibus_adr[AW+1:2]);
                            ram_we    <= 1'b0;
                            ram_sel   <= 4'hF;
                            ram_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state    <= ACK;
                    ram_cyc  <= 1'b0;
                    ram_we   <= 1'b0;
                    ram_sel  <= '0;
                    ibus_ack <= (grant == GNT_IBUS);
                    dbus_ack <= (grant == GNT_DBUS);
                end
                ACK: begin
                    state    <= IDLE;
                    ibus_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arb.sv
// Directed self-checking bench for wb_ram_arb with a registered-read RAM model.
module tb_wb_ram_arb;

    logic        ck;
    logic        rst_n;
    logic        ibus_cyc;
    logic [31:0] ibus_adr;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic        dbus_cyc;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic        ram_cyc;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:255];
    int passes = 0;
    int checks = 0;

    wb_ram_arb #(.WORDS(256)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .ibus_cyc  (ibus_cyc),
        .ibus_adr  (ibus_adr),
        .ibus_rdt  (ibus_rdt),
        .ibus_ack  (ibus_ack),
        .dbus_cyc  (dbus_cyc),
        .dbus_we   (dbus_we),
        .dbus_sel  (dbus_sel),
        .dbus_adr  (dbus_adr),
        .dbus_dat  (dbus_dat),
        .dbus_rdt  (dbus_rdt),
        .dbus_ack  (dbus_ack),
        .ram_cyc   (ram_cyc),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // RAM model: read returns the pre-write word, byte-lane writes
    always @(posedge ck) begin
        if (ram_cyc) begin
            ram_rdata <= mem[ram_addr[7:0]];
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] btb_exp [0:2];
        logic        dgr;
        btb_exp[0] = 32'hA0A0_A0A0;
        btb_exp[1] = 32'hCAFE_F00D;
        btb_exp[2] = 32'h1122_AB44;

        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'hA0A0_A0A0;
        mem[1] = 32'hCAFE_F00D;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'h3333_3333;
        mem[4] = 32'hDEAD_BEEF;
        ram_rdata = '0;

        rst_n = 1'b0;
        ibus_cyc = 1'b0; ibus_adr = '0;
        dbus_cyc = 1'b0; dbus_we = 1'b0; dbus_sel = '0; dbus_adr = '0; dbus_dat = '0;
        step(); step();
        check("rst_ram_cyc", 32'(ram_cyc), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_sel", 32'(ram_sel), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_ibus_ack", 32'(ibus_ack), 32'd0);
        check("rst_dbus_ack", 32'(dbus_ack), 32'd0);
        check("rst_ibus_rdt", ibus_rdt, 32'd0);
        check("rst_dbus_rdt", dbus_rdt, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ram_cyc", 32'(ram_cyc), 32'd0);

        // ibus read of word 4
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0010;
        step();
        check("i_acc_cyc", 32'(ram_cyc), 32'd1);
        check("i_acc_addr", ram_addr, 32'd4);
        check("i_acc_sel", 32'(ram_sel), 32'hF);
        check("i_acc_we", 32'(ram_we), 32'd0);
        check("i_acc_ack", 32'(ibus_ack), 32'd0);
        step();
        check("i_ack", 32'(ibus_ack), 32'd1);
        check("i_rdt", ibus_rdt, 32'hDEAD_BEEF);
        check("i_ack_dack", 32'(dbus_ack), 32'd0);
        check("i_ack_cyc", 32'(ram_cyc), 32'd0);
        ibus_cyc = 1'b0;
        step();
        check("i_post_ack", 32'(ibus_ack), 32'd0);
        step();
        check("i_idle_cyc", 32'(ram_cyc), 32'd0);

        // dbus byte-lane write to word 2, then read back
        dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_sel = 4'b0010;
        dbus_adr = 32'h0000_0008; dbus_dat = 32'h0000_AB00;
        step();
        check("dw_we", 32'(ram_we), 32'd1);
        check("dw_sel", 32'(ram_sel), 32'h2);
        check("dw_addr", ram_addr, 32'd2);
        check("dw_wdata", ram_wdata, 32'h0000_AB00);
        step();
        check("dw_ack", 32'(dbus_ack), 32'd1);
        check("dw_iack", 32'(ibus_ack), 32'd0);
        check("dw_rdt_prewrite", dbus_rdt, 32'h1122_3344);
        check("dw_ack_we", 32'(ram_we), 32'd0);
        dbus_cyc = 1'b0; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_dat = '0;
        step();
        dbus_cyc = 1'b1;
        step();
        check("dr_we", 32'(ram_we), 32'd0);
        step();
        check("dr_ack", 32'(dbus_ack), 32'd1);
        check("dr_rdt", dbus_rdt, 32'h1122_AB44);
        dbus_cyc = 1'b0;
        step();

        // address wrap: 0x404 aliases word 1
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_0404;
        step();
        check("wrap_addr", ram_addr, 32'd1);
        step();
        check("wrap_rdt", dbus_rdt, 32'hCAFE_F00D);
        dbus_cyc = 1'b0;
        step();

        // back-to-back dbus reads, new request presented right after each ack
        dbus_cyc = 1'b1; dbus_adr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b_addr", ram_addr, 32'(i));
            check("b2b_acc_ack", 32'(dbus_ack), 32'd0);
            step();
            check("b2b_ack", 32'(dbus_ack), 32'd1);
            check("b2b_rdt", dbus_rdt, btb_exp[i]);
            if (i < 2) dbus_adr = 32'((i + 1) * 4);
            else dbus_cyc = 1'b0;
            step();
            check("b2b_idle_ack", 32'(dbus_ack), 32'd0);
        end

        // both masters held from reset: last_grant=IBUS so dbus wins first
        rst_n = 1'b0;
        step();
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0010;
        dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_adr = 32'h0000_000C;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            dgr = ((k / 3) % 2) == 0;
            case (k % 3)
                0: begin
                    check("rr_acc_cyc", 32'(ram_cyc), 32'd1);
                    check("rr_acc_addr", ram_addr, dgr ? 32'd3 : 32'd4);
                end
                1: begin
                    check("rr_iack", 32'(ibus_ack), 32'(!dgr));
                    check("rr_dack", 32'(dbus_ack), 32'(dgr));
                    check("rr_rdt", dgr ? dbus_rdt : ibus_rdt, dgr ? 32'h3333_3333 : 32'hDEAD_BEEF);
                end
                default: begin
                    check("rr_idle_acks", 32'({ibus_ack, dbus_ack}), 32'd0);
                end
            endcase
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        step(); step(); step();

        // reset asserted during ACCESS
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0010;
        step();
        check("mr_acc_cyc", 32'(ram_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_cyc", 32'(ram_cyc), 32'd0);
        check("mr_async_ack", 32'(ibus_ack), 32'd0);
        step();
        check("mr_no_ack", 32'(ibus_ack), 32'd0);
        check("mr_held_cyc", 32'(ram_cyc), 32'd0);
        rst_n = 1'b1;
        step();
        check("mr_re_addr", ram_addr, 32'd4);
        check("mr_re_cyc", 32'(ram_cyc), 32'd1);
        step();
        check("mr_re_ack", 32'(ibus_ack), 32'd1);
        check("mr_re_rdt", ibus_rdt, 32'hDEAD_BEEF);
        ibus_cyc = 1'b0;
        step();
        check("mr_re_done", 32'(ibus_ack), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
